rx_shot_sched: RTL and testbench

//  Sequences one measurement "shot" of the two-channel phase receiver.

---
 rtl/rx_sched_pkg.sv | 17 +
 rtl/rx_sched_cmd.sv | 26 ++
 rtl/rx_shot_sched.sv | 151 +++++++++++++++
 tb/tb_rx_shot_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_sched_pkg.sv
// rtl/rx_sched_pkg.sv - shared state encoding and command bytes for the shot scheduler
package rx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    GUARD,
    CAP,
    DUMP,
    HOLD
  } state_t;

  localparam logic [7:0] CMD_SINGLE = 8'h53;
  localparam logic [7:0] CMD_REPEAT = 8'h52;
  localparam logic [7:0] CMD_STOP   = 8'h58;

endpackage

// File: rtl/rx_sched_cmd.sv
// rtl/rx_sched_cmd.sv - registered decode of UART command bytes into one-cycle pulses
module rx_sched_cmd
  import rx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_stb,
  input  logic [7:0] cmd_dat,
  output logic       single_p,
  output logic       repeat_p,
  output logic       stop_p
);

  always_ff @(posedge clk) begin
    if (rst) begin
      single_p <= 1'b0;
      repeat_p <= 1'b0;
      stop_p   <= 1'b0;
    end else begin
      single_p <= cmd_stb && (cmd_dat == CMD_SINGLE);
      repeat_p <= cmd_stb && (cmd_dat == CMD_REPEAT);
      stop_p   <= cmd_stb && (cmd_dat == CMD_STOP);
    end
  end

endmodule

// File: rtl/rx_shot_sched.sv
// rtl/rx_shot_sched.sv - TX burst / guard / capture / dump sequencer for one receiver shot
module rx_shot_sched
  import rx_sched_pkg::*;
#(
  parameter int TX_CYC      = 4800,
  parameter int GUARD_CYC   = 96,
  parameter int CAP_LEN     = 1024,
  parameter int HOLDOFF_CYC = 48000,
  parameter int CNTW        = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_stb,
  input  logic [7:0]                 cmd_dat,
  input  logic                       dump_done,
  output logic                       tx_en,
  output logic                       rx_blank,
  output logic                       cap_we,
  output logic [$clog2(CAP_LEN)-1:0] cap_addr,
  output logic                       dump_req,
  output logic                       busy,
  output logic [7:0]                 shot_cnt,
  output logic                       cmd_ovr
);

  localparam int AW = $clog2(CAP_LEN);

  state_t          state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic [AW-1:0]   addr_nx;
  logic            rpt, rpt_nx;
  logic            ovr_nx;
  logic [7:0]      shots_nx;
  logic            single_p, repeat_p, stop_p;

  rx_sched_cmd u_cmd (
    .clk      (clk),
    .rst      (rst),
    .cmd_stb  (cmd_stb),
    .cmd_dat  (cmd_dat),
    .single_p (single_p),
    .repeat_p (repeat_p),
    .stop_p   (stop_p)
  );

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rpt      <= 1'b0;
      tx_en    <= 1'b0;
      rx_blank <= 1'b0;
      cap_we   <= 1'b0;
      cap_addr <= '0;
      dump_req <= 1'b0;
      busy     <= 1'b0;
      shot_cnt <= 8'd0;
      cmd_ovr  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rpt      <= rpt_nx;
      tx_en    <= (state_nx == TX);
      rx_blank <= (state_nx == TX) || (state_nx == GUARD);
      cap_we   <= (state_nx == CAP);
      cap_addr <= addr_nx;
      dump_req <= (state_nx == DUMP);
      busy     <= (state_nx != IDLE);
      shot_cnt <= shots_nx;
      cmd_ovr  <= ovr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = cap_addr;
    rpt_nx   = rpt;
    ovr_nx   = cmd_ovr;
    shots_nx = shot_cnt;

    case (state)
      TX: begin
        if (cnt == '0) begin
          state_nx = GUARD;
          cnt_nx   = CNTW'(GUARD_CYC - 1);
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      GUARD: begin
        if (cnt == '0) begin
          state_nx = CAP;
          addr_nx  = '0;
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      CAP: begin
        if (cap_addr == AW'(CAP_LEN - 1)) begin
          state_nx = DUMP;
          addr_nx  = '0;
        end else begin
          addr_nx = cap_addr + AW'(1);
        end
      end
      DUMP: begin
        if (dump_done) begin
          shots_nx = shot_cnt + 8'd1;
          if (rpt) begin
            state_nx = HOLD;
            cnt_nx   = CNTW'(HOLDOFF_CYC - 1);
          end else begin
            state_nx = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = TX;
          cnt_nx   = CNTW'(TX_CYC - 1);
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      default: ;
    endcase

    // Commands act on the state just chosen; a capture already underway is never cut short.
    if (stop_p) begin
      rpt_nx = 1'b0;
      ovr_nx = 1'b0;
      if (state_nx == TX || state_nx == GUARD || state_nx == HOLD) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end

    if (single_p || repeat_p) begin
      if (state_nx == IDLE) begin
        state_nx = TX;
        cnt_nx   = CNTW'(TX_CYC - 1);
        rpt_nx   = repeat_p;
      end else begin
        ovr_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_shot_sched.sv
// tb/tb_rx_shot_sched.sv - directed and random checks of rx_shot_sched against a shot-timeline model
module tb_rx_shot_sched;

  localparam int TXC  = 8;
  localparam int GC   = 4;
  localparam int CL   = 16;
  localparam int HC   = 20;
  localparam int SHOT = TXC + GC + CL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_stb = 1'b0;
  logic [7:0] cmd_dat = 8'h00;
  logic       dump_done = 1'b0;
  logic       tx_en, rx_blank, cap_we, dump_req, busy, cmd_ovr;
  logic [3:0] cap_addr;
  logic [7:0] shot_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = off, 1 = in shot at elapsed cycle m_t, 2 = awaiting dump, 3 = holdoff at m_h.
  int m_mode, m_t, m_h, m_shots;
  bit m_rpt, m_ovr, p_s, p_r, p_x;
  int tx_cnt, cap_cnt, gap_cnt, dreq_cnt;

  always #5 clk = ~clk;

  rx_shot_sched #(
    .TX_CYC      (TXC),
    .GUARD_CYC   (GC),
    .CAP_LEN     (CL),
    .HOLDOFF_CYC (HC),
    .CNTW        (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_stb   (cmd_stb),
    .cmd_dat   (cmd_dat),
    .dump_done (dump_done),
    .tx_en     (tx_en),
    .rx_blank  (rx_blank),
    .cap_we    (cap_we),
    .cap_addr  (cap_addr),
    .dump_req  (dump_req),
    .busy      (busy),
    .shot_cnt  (shot_cnt),
    .cmd_ovr   (cmd_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit es, er, ex;
    if (rst) begin
      m_mode = 0; m_t = 0; m_h = 0; m_shots = 0;
      m_rpt = 0; m_ovr = 0; p_s = 0; p_r = 0; p_x = 0;
      return;
    end
    es = p_s; er = p_r; ex = p_x;
    p_s = cmd_stb && (cmd_dat == 8'h53);
    p_r = cmd_stb && (cmd_dat == 8'h52);
    p_x = cmd_stb && (cmd_dat == 8'h58);
    case (m_mode)
      1: begin
        m_t++;
        if (m_t == SHOT) m_mode = 2;
      end
      2: if (dump_done) begin
        m_shots = (m_shots + 1) % 256;
        if (m_rpt) begin m_mode = 3; m_h = 0; end
        else m_mode = 0;
      end
      3: begin
        m_h++;
        if (m_h == HC) begin m_mode = 1; m_t = 0; end
      end
      default: ;
    endcase
    if (ex) begin
      m_rpt = 0;
      m_ovr = 0;
      if ((m_mode == 1 && m_t < TXC + GC) || m_mode == 3) m_mode = 0;
    end
    if (es || er) begin
      if (m_mode == 0) begin m_mode = 1; m_t = 0; m_rpt = er; end
      else m_ovr = 1;
    end
  endtask

  task automatic compare_all();
    bit e_we;
    e_we = (m_mode == 1) && (m_t >= TXC + GC);
    check("tx_en", tx_en, (m_mode == 1) && (m_t < TXC));
    check("rx_blank", rx_blank, (m_mode == 1) && (m_t < TXC + GC));
    check("cap_we", cap_we, e_we);
    check("cap_addr", cap_addr, e_we ? (m_t - TXC - GC) : 0);
    check("dump_req", dump_req, m_mode == 2);
    check("busy", busy, m_mode != 0);
    check("shot_cnt", shot_cnt, m_shots);
    check("cmd_ovr", cmd_ovr, m_ovr);
    check("tx_cap_excl", tx_en & cap_we, 0);
    check("blank_covers_tx", tx_en & ~rx_blank, 0);
    if (tx_en) tx_cnt++;
    if (cap_we) cap_cnt++;
    if (rx_blank && !tx_en) gap_cnt++;
    if (dump_req) dreq_cnt++;
  endtask

  task automatic cycle(input bit stb, input logic [7:0] dat, input bit dd);
    cmd_stb   = stb;
    cmd_dat   = dat;
    dump_done = dd;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  function automatic bit hit(input int sel);
    case (sel)
      0: return dump_req;
      1: return cap_we;
      2: return tx_en;
      default: return cap_we && (cap_addr == 4'd7);
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag);
    int n = 0;
    while (!hit(sel) && n < budget) begin
      idle(1);
      n++;
    end
    if (!hit(sel)) check(tag, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic clr_counts();
    tx_cnt = 0; cap_cnt = 0; gap_cnt = 0; dreq_cnt = 0;
  endtask

  initial begin
    int n;
    logic [7:0] dat;

    // Reset state
    do_reset();
    check("rst_tx_en", tx_en, 0);
    check("rst_busy", busy, 0);
    check("rst_shot_cnt", shot_cnt, 0);
    check("rst_cap_addr", cap_addr, 0);

    // Single shot timing
    clr_counts();
    cycle(1'b1, 8'h53, 1'b0);
    wait_for(0, 100, "single_dump_timeout");
    check("single_tx_cycles", tx_cnt, TXC);
    check("single_gap_cycles", gap_cnt, GC);
    check("single_cap_cycles", cap_cnt, CL);
    idle(3);
    cycle(1'b0, 8'h00, 1'b1);
    idle(1);
    check("single_shot_cnt", shot_cnt, 1);
    check("single_idle", busy, 0);

    // Repeat mode: three shots with exact holdoff, then stop during HOLD
    do_reset();
    cycle(1'b1, 8'h52, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_for(0, 200, "rpt_dump_timeout");
      cycle(1'b0, 8'h00, 1'b1);
      if (k < 2) begin
        n = 0;
        while (!tx_en && n < 100) begin
          idle(1);
          n++;
        end
        check("rpt_hold_gap", n, HC);
      end
    end
    check("rpt_shot_cnt", shot_cnt, 3);
    idle(5);
    cycle(1'b1, 8'h58, 1'b0);
    clr_counts();
    idle(40);
    check("rpt_stop_no_tx", tx_cnt, 0);
    check("rpt_stop_idle", busy, 0);

    // Stop during TX
    do_reset();
    clr_counts();
    cycle(1'b1, 8'h53, 1'b0);
    idle(2);
    cycle(1'b1, 8'h58, 1'b0);
    idle(40);
    check("abort_tx_cycles", tx_cnt, 3);
    check("abort_no_cap", cap_cnt, 0);
    check("abort_no_dump", dreq_cnt, 0);
    check("abort_shot_cnt", shot_cnt, 0);

    // Command while busy sets overrun; stop clears it; junk byte ignored
    do_reset();
    cycle(1'b1, 8'h53, 1'b0);
    wait_for(1, 100, "ovr_cap_timeout");
    cycle(1'b1, 8'h53, 1'b0);
    wait_for(0, 100, "ovr_dump_timeout");
    cycle(1'b0, 8'h00, 1'b1);
    idle(1);
    check("ovr_set", cmd_ovr, 1);
    check("ovr_shot_cnt", shot_cnt, 1);
    check("ovr_idle", busy, 0);
    cycle(1'b1, 8'h58, 1'b0);
    idle(2);
    check("ovr_cleared", cmd_ovr, 0);
    cycle(1'b1, 8'h41, 1'b0);
    idle(3);
    check("junk_idle", busy, 0);
    check("junk_shot_cnt", shot_cnt, 1);

    // Reset mid-capture
    do_reset();
    cycle(1'b1, 8'h53, 1'b0);
    wait_for(3, 100, "midcap_timeout");
    check("midcap_addr", cap_addr, 7);
    rst = 1'b1;
    idle(1);
    check("midcap_rst_outs", {tx_en, rx_blank, cap_we, cap_addr, dump_req, busy, shot_cnt, cmd_ovr}, 0);
    rst = 1'b0;
    cycle(1'b1, 8'h53, 1'b0);
    wait_for(1, 100, "fresh_cap_timeout");
    check("fresh_cap_addr", cap_addr, 0);

    // 256 single shots wrap the shot counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 8'h53, 1'b0);
      wait_for(0, 100, "wrap_dump_timeout");
      cycle(1'b0, 8'h00, 1'b1);
      idle(1);
    end
    check("wrap_shot_cnt", shot_cnt, 0);

    // Random commands, dump strobes and occasional reset
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 4))
        0: dat = 8'h53;
        1: dat = 8'h52;
        2: dat = 8'h58;
        3: dat = 8'h41;
        default: dat = 8'($urandom);
      endcase
      rst = ($urandom_range(0, 499) == 0);
      cycle($urandom_range(0, 15) == 0, dat, $urandom_range(0, 5) == 0);
    end
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
